// File: rtl/systolic_mac_row.sv
// -----------------------------------------------------------------------------
// systolic_mac_row
//   Weight-stationary systolic dot-product row. It consumes the skewed lane
//   stream of the matrix row buffer. Lane u carries row k on pass cycle k+u.
//   The block emits one signed result per row, tagged with the row index.
//
//   Optional feature: define MAC_RELU_EN to clamp negative results to zero.
//   The clamp is combinational on the final chain register, so the latency
//   does not change. With MAC_RELU_EN undefined, res_o is the raw signed sum.
// -----------------------------------------------------------------------------
module systolic_mac_row #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int LANES        = 3,
    parameter int MEM_DEPTH    = 8,
    parameter int ACC_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH + $clog2(LANES),
    parameter int PCNT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              w_load,
    input  logic [LANES*WEIGHT_WIDTH-1:0]     w_i,
    input  logic                              data_valid_i,
    input  logic [LANES*DATA_WIDTH-1:0]       row_i,
    output logic                              res_valid_o,
    output logic signed [ACC_WIDTH-1:0]       res_o,
    output logic [$clog2(MEM_DEPTH)-1:0]      res_idx_o,
    output logic                              pass_done_o,
    output logic [PCNT_WIDTH-1:0]             pass_cnt_o,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int IDX_WIDTH = $clog2(MEM_DEPTH);
    // The input counter must reach MEM_DEPTH+LANES-2, which is the last skewed cycle.
    localparam int CNT_WIDTH = $clog2(MEM_DEPTH + LANES);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MEM_DEPTH + LANES - 2);
    localparam logic [CNT_WIDTH-1:0] ROWS_CNT = CNT_WIDTH'(MEM_DEPTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MEM_DEPTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [0:0]                     r_state;
    logic [CNT_WIDTH-1:0]           r_in_cnt;
    logic signed [WEIGHT_WIDTH-1:0] r_w_shadow [LANES];
    logic signed [WEIGHT_WIDTH-1:0] r_w_active [LANES];
    logic signed [ACC_WIDTH-1:0]    r_psum     [LANES];
    logic                           r_tag_v    [LANES];
    logic [IDX_WIDTH-1:0]           r_tag_idx  [LANES];
    logic                           r_err;
    logic [PCNT_WIDTH-1:0]          r_pass_cnt;

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    logic                           w_start;
    logic                           w_run;
    logic                           w_abort;
    logic                           w_finish;
    logic                           w_proc;
    logic [CNT_WIDTH-1:0]           w_cnt;
    logic                           w_ins_v;
    logic [IDX_WIDTH-1:0]           w_ins_idx;
    logic                           w_tag_nxt_v;
    logic [IDX_WIDTH-1:0]           w_tag_nxt_idx;
    logic signed [WEIGHT_WIDTH-1:0] w_w_eff [LANES];
    logic signed [ACC_WIDTH-1:0]    w_prod  [LANES];
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_res;

    // This function multiplies an unsigned activation by a signed weight.
    // Both operands are extended to ACC_WIDTH, so the product wraps
    // modulo 2^ACC_WIDTH like the sums in the chain.
    function automatic logic signed [ACC_WIDTH-1:0] f_mac_prod(
        input logic        [DATA_WIDTH-1:0]   x,
        input logic signed [WEIGHT_WIDTH-1:0] w
    );
        logic signed [ACC_WIDTH-1:0] x_ext;
        logic signed [ACC_WIDTH-1:0] w_ext;
        x_ext = signed'({{(ACC_WIDTH-DATA_WIDTH){1'b0}}, x});
        w_ext = {{(ACC_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
        return x_ext * w_ext;
    endfunction

    // -------------------------------------------------------------------------
    // Pass control decode
    // -------------------------------------------------------------------------
    assign w_run    = (r_state == ST_RUN);
    assign w_start  = (r_state == ST_IDLE) && data_valid_i;
    assign w_abort  = w_run && !data_valid_i && (r_in_cnt < LAST_CNT);
    assign w_finish = w_run && data_valid_i && (r_in_cnt == LAST_CNT);
    assign w_proc   = w_start || (w_run && data_valid_i);
    // The start cycle is pass cycle 0, even though the counter still holds its idle value.
    assign w_cnt     = w_start ? '0 : r_in_cnt;
    assign w_ins_v   = w_proc && (w_cnt < ROWS_CNT);
    assign w_ins_idx = w_cnt[IDX_WIDTH-1:0];

    // This block selects the weights per lane and forms the products.
    // At pass start the new shadow weights are already in effect for cycle 0.
    // NOTE: every element is assigned on every pass through the block, so no latch is inferred.
    always_comb begin
        for (int u = 0; u < LANES; u++) begin
            w_w_eff[u] = w_start ? r_w_shadow[u] : r_w_active[u];
            w_prod[u]  = f_mac_prod(row_i[u*DATA_WIDTH +: DATA_WIDTH], w_w_eff[u]);
        end
    end

    // This block is the pass FSM and the skewed input-cycle counter.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_in_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (data_valid_i) begin
                        r_state  <= ST_RUN;
                        r_in_cnt <= CNT_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (w_finish || w_abort) begin
                        r_state  <= ST_IDLE;
                        r_in_cnt <= '0;
                    end else if (data_valid_i) begin
                        r_in_cnt <= r_in_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_in_cnt <= '0;
                end
            endcase
        end
    end

    // This block holds the shadow weights, which w_load writes at any time.
    // It also holds the active weights, which are swapped in only at pass start.
    // NOTE: these arrays are a few flops each, not a RAM, so they take the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < LANES; u++) begin
                r_w_shadow[u] <= '0;
                r_w_active[u] <= '0;
            end
        end else begin
            for (int u = 0; u < LANES; u++) begin
                if (w_load) begin
                    r_w_shadow[u] <= w_i[u*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                end
                if (w_start) begin
                    r_w_active[u] <= r_w_shadow[u];
                end
            end
        end
    end

    // This block is the systolic partial-sum chain. Stage u adds its lane product
    // to the partial sum of stage u-1, so row k leaves the last stage LANES cycles after it entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < LANES; u++) begin
                r_psum[u] <= '0;
            end
        end else begin
            r_psum[0] <= w_prod[0];
            for (int u = 1; u < LANES; u++) begin
                r_psum[u] <= r_psum[u-1] + w_prod[u];
            end
        end
    end

    // This block is the row-tag pipeline. It runs in step with the chain and is
    // flushed on abort, so a truncated pass emits nothing more.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < LANES; u++) begin
                r_tag_v[u]   <= 1'b0;
                r_tag_idx[u] <= '0;
            end
        end else if (w_abort) begin
            for (int u = 0; u < LANES; u++) begin
                r_tag_v[u]   <= 1'b0;
                r_tag_idx[u] <= '0;
            end
        end else begin
            r_tag_v[0]   <= w_ins_v;
            r_tag_idx[0] <= w_ins_v ? w_ins_idx : '0;
            for (int u = 1; u < LANES; u++) begin
                r_tag_v[u]   <= r_tag_v[u-1];
                r_tag_idx[u] <= r_tag_idx[u-1];
            end
        end
    end

    // The pass counter looks one stage ahead of the output tag. This way it
    // increments on the same edge that presents the last row of a pass.
    generate
        if (LANES == 1) begin : g_tag_nxt_single
            assign w_tag_nxt_v   = w_ins_v;
            assign w_tag_nxt_idx = w_ins_idx;
        end else begin : g_tag_nxt_chain
            assign w_tag_nxt_v   = r_tag_v[LANES-2];
            assign w_tag_nxt_idx = r_tag_idx[LANES-2];
        end
    endgenerate

    // This block holds the sticky truncation flag and the completed-pass counter.
    // If an abort and a w_load arrive in the same cycle, the abort wins and err_o stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_pass_cnt <= '0;
        end else begin
            if (w_abort) begin
                r_err <= 1'b1;
            end else if (w_load) begin
                r_err <= 1'b0;
            end
            if (!w_abort && w_tag_nxt_v && (w_tag_nxt_idx == LAST_IDX)) begin
                r_pass_cnt <= r_pass_cnt + PCNT_WIDTH'(1);
            end
        end
    end

    // This block forms the outputs. Result and index are forced to zero
    // whenever the beat is not valid.
    always_comb begin
        w_sum = r_psum[LANES-1];
`ifdef MAC_RELU_EN
        w_res = w_sum[ACC_WIDTH-1] ? '0 : w_sum;
`else
        w_res = w_sum;
`endif
        res_valid_o = r_tag_v[LANES-1];
        res_o       = r_tag_v[LANES-1] ? w_res : '0;
        res_idx_o   = r_tag_v[LANES-1] ? r_tag_idx[LANES-1] : '0;
        pass_done_o = r_tag_v[LANES-1] && (r_tag_idx[LANES-1] == LAST_IDX);
        pass_cnt_o  = r_pass_cnt;
        busy_o      = w_run;
        err_o       = r_err;
    end

endmodule

// File: tb/tb_systolic_mac_row.sv
// -----------------------------------------------------------------------------
// tb_systolic_mac_row
//   Scoreboard bench for systolic_mac_row. Each pass pushes its expected
//   results, each tagged with the cycle it is due. Every sampled cycle pops
//   and compares the entry. Compile with MAC_RELU_EN to match a ReLU build.
// -----------------------------------------------------------------------------
module tb_systolic_mac_row;

    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int LANES = 3;
    localparam int MD    = 8;
    localparam int ACC   = DW + WW + $clog2(LANES);
    localparam int PW    = 8;
    localparam int IW    = $clog2(MD);

    logic                   clk;
    logic                   rst;
    logic                   w_load;
    logic [LANES*WW-1:0]    w_i;
    logic                   data_valid_i;
    logic [LANES*DW-1:0]    row_i;
    logic                   res_valid_o;
    logic signed [ACC-1:0]  res_o;
    logic [IW-1:0]          res_idx_o;
    logic                   pass_done_o;
    logic [PW-1:0]          pass_cnt_o;
    logic                   busy_o;
    logic                   err_o;

    systolic_mac_row #(
        .DATA_WIDTH  (DW),
        .WEIGHT_WIDTH(WW),
        .LANES       (LANES),
        .MEM_DEPTH   (MD),
        .ACC_WIDTH   (ACC),
        .PCNT_WIDTH  (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_load      (w_load),
        .w_i         (w_i),
        .data_valid_i(data_valid_i),
        .row_i       (row_i),
        .res_valid_o (res_valid_o),
        .res_o       (res_o),
        .res_idx_o   (res_idx_o),
        .pass_done_o (pass_done_o),
        .pass_cnt_o  (pass_cnt_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ACC-1:0] res;
        int             idx;
        int             due;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   beats    = 0;
    int   m_pcnt   = 0;
    int   pat      [LANES][MD];
    int   m_shadow [LANES];
    int   m_active [LANES];
    int   wl_next  [LANES];

    // This task advances one cycle and samples at the falling edge.
    // It pops and compares any scoreboard entry that is due.
    task automatic tick();
        exp_t e;
        logic exp_v;
        logic exp_done;
        @(negedge clk);
        cyc++;
        exp_v    = (sb.size() > 0) && (sb[0].due == cyc);
        exp_done = 1'b0;
        n_checks++;
        if (res_valid_o !== exp_v) $display("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, res_valid_o, exp_v);
        else n_pass++;
        if (exp_v) begin
            e = sb.pop_front();
            beats++;
            n_checks++;
            if (res_o !== e.res) $display("FAIL res cyc=%0d got=%0d exp=%0d", cyc, res_o, $signed(e.res));
            else n_pass++;
            n_checks++;
            if (res_idx_o !== IW'(e.idx)) $display("FAIL res_idx cyc=%0d got=%0d exp=%0d", cyc, res_idx_o, e.idx);
            else n_pass++;
            exp_done = (e.idx == MD - 1);
            if (exp_done) m_pcnt++;
        end else begin
            n_checks++;
            if (res_o !== '0 || res_idx_o !== '0)
                $display("FAIL idle_zero cyc=%0d got res=%0d idx=%0d exp 0/0", cyc, res_o, res_idx_o);
            else n_pass++;
        end
        n_checks++;
        if (pass_done_o !== exp_done) $display("FAIL pass_done cyc=%0d got=%b exp=%b", cyc, pass_done_o, exp_done);
        else n_pass++;
        n_checks++;
        if (pass_cnt_o !== PW'(m_pcnt)) $display("FAIL pass_cnt cyc=%0d got=%0d exp=%0d", cyc, pass_cnt_o, PW'(m_pcnt));
        else n_pass++;
    endtask

    // This task drives the skewed lane data for pass cycle c from pat.
    task automatic drive_row(input int c);
        int k;
        int v;
        row_i = '0;
        for (int u = 0; u < LANES; u++) begin
            k = c - u;
            if (k >= 0 && k < MD) begin
                v = pat[u][k];
                row_i[u*DW +: DW] = v[DW-1:0];
            end
        end
    endtask

    task automatic push_expected(input int n_rows, input int start);
        exp_t e;
        int   sum;
        for (int k = 0; k < n_rows; k++) begin
            sum = 0;
            for (int u = 0; u < LANES; u++) sum += m_active[u] * pat[u][k];
`ifdef MAC_RELU_EN
            if (sum < 0) sum = 0;
`endif
            e.res = ACC'(sum);
            e.idx = k;
            e.due = start + k + LANES;
            sb.push_back(e);
        end
    endtask

    task automatic set_w(input int a, input int b, input int c);
        int v [LANES];
        v[0] = a; v[1] = b; v[2] = c;
        for (int u = 0; u < LANES; u++) w_i[u*WW +: WW] = v[u][WW-1:0];
    endtask

    task automatic load_weights(input int a, input int b, input int c);
        w_load = 1'b1;
        set_w(a, b, c);
        m_shadow[0] = a; m_shadow[1] = b; m_shadow[2] = c;
        tick();
        w_load = 1'b0;
    endtask

    task automatic idle(input int n);
        data_valid_i = 1'b0;
        row_i        = '0;
        w_load       = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // This task runs one pass. At abort_at it drops the valid and ends.
    // At stop_at it returns before driving that cycle.
    // At wl_at it loads wl_next into the shadow weights.
    task automatic run_pass(input int abort_at, input int stop_at, input int wl_at);
        int n_rows;
        for (int u = 0; u < LANES; u++) m_active[u] = m_shadow[u];
        n_rows = MD;
        if (abort_at >= 0) n_rows = (abort_at >= LANES) ? abort_at - LANES + 1 : 0;
        push_expected(n_rows, cyc);
        for (int c = 0; c <= MD + LANES - 2; c++) begin
            if (c == stop_at) return;
            if (c == abort_at) begin
                data_valid_i = 1'b0;
                row_i        = '0;
                w_load       = 1'b0;
                tick();
                return;
            end
            data_valid_i = 1'b1;
            drive_row(c);
            if (c == wl_at) begin
                w_load = 1'b1;
                set_w(wl_next[0], wl_next[1], wl_next[2]);
                for (int u = 0; u < LANES; u++) m_shadow[u] = wl_next[u];
            end else begin
                w_load = 1'b0;
            end
            tick();
            if (c == 0) begin
                n_checks++;
                if (busy_o !== 1'b1) $display("FAIL busy_run cyc=%0d got=%b exp=1", cyc, busy_o);
                else n_pass++;
            end
        end
        data_valid_i = 1'b0;
        row_i        = '0;
        w_load       = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s_drain pending=%0d exp=0", name, sb.size());
        else n_pass++;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (res_valid_o !== 1'b0 || res_o !== '0 || res_idx_o !== '0 || pass_done_o !== 1'b0 ||
            pass_cnt_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL %s got v=%b res=%0d idx=%0d done=%b cnt=%0d busy=%b err=%b exp all 0",
                     name, res_valid_o, res_o, res_idx_o, pass_done_o, pass_cnt_o, busy_o, err_o);
        else n_pass++;
    endtask

    task automatic set_ramp();
        for (int u = 0; u < LANES; u++)
            for (int k = 0; k < MD; k++) pat[u][k] = k + 1;
    endtask

    task automatic set_const(input int v);
        for (int u = 0; u < LANES; u++)
            for (int k = 0; k < MD; k++) pat[u][k] = v;
    endtask

    task automatic test_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_pass();
        load_weights(1, 2, 3);
        set_ramp();
        run_pass(-1, -1, -1);
        idle(LANES + 1);
        check_drained("single");
        n_checks++;
        if (pass_cnt_o !== PW'(1)) $display("FAIL single_pcnt got=%0d exp=1", pass_cnt_o);
        else n_pass++;
    endtask

    task automatic test_negative();
        load_weights(-1, -1, -1);
        set_const(255);
        run_pass(-1, -1, -1);
        idle(LANES + 1);
        check_drained("negative");
    endtask

    task automatic test_gap1_swap();
        load_weights(1, 1, 1);
        set_const(1);
        wl_next[0] = 2; wl_next[1] = 2; wl_next[2] = 2;
        run_pass(-1, -1, 4);
        idle(1);
        run_pass(-1, -1, -1);
        idle(LANES + 1);
        check_drained("gap1");
    endtask

    task automatic test_abort();
        load_weights(1, 2, 3);
        set_ramp();
        run_pass(4, -1, -1);
        n_checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL abort_err got err=%b busy=%b exp err=1 busy=0", err_o, busy_o);
        else n_pass++;
        idle(LANES + 2);
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL abort_sticky got=%b exp=1", err_o);
        else n_pass++;
        load_weights(1, 2, 3);
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL abort_clear got=%b exp=0", err_o);
        else n_pass++;
        run_pass(-1, -1, -1);
        idle(LANES + 1);
        check_drained("abort");
    endtask

    task automatic test_reset_mid();
        load_weights(1, 2, 3);
        set_ramp();
        run_pass(-1, 5, -1);
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        sb.delete();
        m_pcnt = 0;
        for (int u = 0; u < LANES; u++) m_shadow[u] = 0;
        data_valid_i = 1'b0;
        row_i        = '0;
        tick();
        tick();
        rst = 1'b0;
        load_weights(1, 2, 3);
        run_pass(-1, -1, -1);
        idle(LANES + 1);
        check_drained("reset_mid");
    endtask

    task automatic test_back_to_back();
        load_weights(3, -2, 5);
        for (int u = 0; u < LANES; u++)
            for (int k = 0; k < MD; k++) pat[u][k] = (37 * u + 29 * k + 11) % 256;
        beats = 0;
        run_pass(-1, -1, -1);
        run_pass(-1, -1, -1);
        idle(LANES + 1);
        n_checks++;
        if (beats !== 16) $display("FAIL b2b_beats got=%0d exp=16", beats);
        else n_pass++;
        check_drained("b2b");
    endtask

    initial begin
        rst          = 1'b1;
        w_load       = 1'b0;
        w_i          = '0;
        data_valid_i = 1'b0;
        row_i        = '0;
        for (int u = 0; u < LANES; u++) begin
            m_shadow[u] = 0;
            m_active[u] = 0;
            wl_next[u]  = 0;
        end
        test_reset();
        test_single_pass();
        test_negative();
        test_gap1_swap();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
